ctrl_sequencer: RTL and testbench

- Main control FSM for the 16-bit/8-bit-address core.
- Sequences the fetch stage by pulsing activateFetch and decodes the latched instruction word.
- Owns the single shared memory port: muxes the fetch PC address against the load/store data address and generates ALU, register-write and memory-write strobes.
- Sits between the fetch stage, the datapath and the unified instruction/data memory.

---
 rtl/ctrl_sequencer_if.sv | 31 +++
 rtl/ctrl_sequencer.sv | 141 ++++++++++++++
 tb/tb_ctrl_sequencer.sv | 366 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ctrl_sequencer_if.sv
// Bundle between the sequencer and its fetch stage, datapath and the unified memory port.
interface ctrl_sequencer_if;
    logic        start;
    logic [15:0] instr;
    logic [7:0]  pc_addr;
    logic [7:0]  data_addr;
    logic [15:0] store_data;
    logic        activateFetch;
    logic [7:0]  mem_addr;
    logic        mem_we;
    logic [15:0] mem_wdata;
    logic        alu_en;
    logic        reg_we;
    logic        load_sel;
    logic        busy;
    logic        halted;
    logic        illegal;
    logic [15:0] retired;

    modport master (
        input  start, instr, pc_addr, data_addr, store_data,
        output activateFetch, mem_addr, mem_we, mem_wdata, alu_en, reg_we,
               load_sel, busy, halted, illegal, retired
    );

    modport slave (
        output start, instr, pc_addr, data_addr, store_data,
        input  activateFetch, mem_addr, mem_we, mem_wdata, alu_en, reg_we,
               load_sel, busy, halted, illegal, retired
    );
endinterface

// File: rtl/ctrl_sequencer.sv
// Main control FSM: fetch/decode sequencing and ownership of the shared memory port.
// IDLE wait start | FETCH pc on port | DECODE | EXEC one cycle | MEM_RD load wait | HALT until reset
module ctrl_sequencer #(
    parameter int MEM_LATENCY = 1,
    parameter int CNT_W       = 3
) (
    input  logic             clock,
    input  logic             reset,
    ctrl_sequencer_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM_RD, S_HALT
    } state_t;

    localparam logic [CNT_W-1:0] LAT = CNT_W'(MEM_LATENCY);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [15:0]      retired_q, retired_d;
    logic [3:0]       op_q, op_d;
    logic [3:0]       opcode;
    logic             wait_done;

    logic        af, we, alu, rwe, lsel, busy, halted, ill;
    logic [7:0]  addr;
    logic [15:0] wdata;

    assign opcode    = bus.instr[15:12];
    assign wait_done = (cnt_q == LAT);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            retired_q <= '0;
            op_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            retired_q <= retired_d;
            op_q      <= op_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        retired_d = retired_q;
        op_d      = op_q;
        af        = 1'b0;
        we        = 1'b0;
        alu       = 1'b0;
        rwe       = 1'b0;
        lsel      = 1'b0;
        busy      = 1'b0;
        halted    = 1'b0;
        ill       = 1'b0;
        addr      = '0;
        wdata     = '0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_FETCH;
                    cnt_d   = '0;
                end
            end
            S_FETCH: begin
                busy  = 1'b1;
                addr  = bus.pc_addr;
                cnt_d = cnt_q + 1'b1;
                if (wait_done) begin
                    af      = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                busy = 1'b1;
                op_d = opcode;
                case (opcode)
                    4'h8: begin
                        state_d = S_MEM_RD;
                        cnt_d   = '0;
                    end
                    4'hF: begin
                        state_d   = S_HALT;
                        retired_d = retired_q + 16'd1;
                    end
                    4'hA, 4'hB, 4'hC, 4'hD, 4'hE: begin
                        ill     = 1'b1;
                        state_d = S_EXEC;
                    end
                    default: state_d = S_EXEC;
                endcase
            end
            S_EXEC: begin
                busy = 1'b1;
                case (op_q)
                    4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7: begin
                        alu = 1'b1;
                        rwe = 1'b1;
                    end
                    4'h9: begin
                        we    = 1'b1;
                        addr  = bus.data_addr;
                        wdata = bus.store_data;
                    end
                    default: ;
                endcase
                state_d   = S_FETCH;
                cnt_d     = '0;
                retired_d = retired_q + 16'd1;
            end
            S_MEM_RD: begin
                busy  = 1'b1;
                addr  = bus.data_addr;
                cnt_d = cnt_q + 1'b1;
                if (wait_done) begin
                    rwe       = 1'b1;
                    lsel      = 1'b1;
                    state_d   = S_FETCH;
                    cnt_d     = '0;
                    retired_d = retired_q + 16'd1;
                end
            end
            S_HALT:  halted = 1'b1;
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.activateFetch = af;
    assign bus.mem_we        = we;
    assign bus.alu_en        = alu;
    assign bus.reg_we        = rwe;
    assign bus.load_sel      = lsel;
    assign bus.busy          = busy;
    assign bus.halted        = halted;
    assign bus.illegal       = ill;
    assign bus.mem_addr      = addr;
    assign bus.mem_wdata     = wdata;
    assign bus.retired       = retired_q;
endmodule

// File: tb/tb_ctrl_sequencer.sv
// Bench for ctrl_sequencer: three instances at memory latencies 0, 1 and 2, each checked against
// a per-instruction cycle trace derived from the instruction class and latency.
module tb_ctrl_sequencer;
    localparam int NL = 3;

    typedef struct packed {
        logic        af, we, alu, rwe, lsel, busy, halted, ill;
        logic [7:0]  addr;
        logic [15:0] wdata;
        logic [15:0] ret;
    } cyc_t;

    logic        clk = 1'b0;
    logic        rst_v   [NL];
    logic        start_v [NL];
    logic [15:0] instr_v [NL];
    logic [7:0]  pc_v    [NL];
    logic [7:0]  da_v    [NL];
    logic [15:0] sd_v    [NL];
    logic [7:0]  strb_o  [NL];
    logic [7:0]  addr_o  [NL];
    logic [15:0] wdata_o [NL];
    logic [15:0] ret_o   [NL];

    cyc_t        exp_q[$];
    logic [15:0] ret_m [NL];
    int          total = 0;
    int          bad   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NL; g++) begin : u
        ctrl_sequencer_if bus ();
        ctrl_sequencer #(.MEM_LATENCY(g), .CNT_W(3)) dut (
            .clock (clk),
            .reset (rst_v[g]),
            .bus   (bus.master)
        );
        assign bus.start      = start_v[g];
        assign bus.instr      = instr_v[g];
        assign bus.pc_addr    = pc_v[g];
        assign bus.data_addr  = da_v[g];
        assign bus.store_data = sd_v[g];
        assign strb_o[g]  = {bus.activateFetch, bus.mem_we, bus.alu_en, bus.reg_we,
                             bus.load_sel, bus.busy, bus.halted, bus.illegal};
        assign addr_o[g]  = bus.mem_addr;
        assign wdata_o[g] = bus.mem_wdata;
        assign ret_o[g]   = bus.retired;
    end

    function automatic cyc_t sample(int k);
        cyc_t s;
        s = {strb_o[k], addr_o[k], wdata_o[k], ret_o[k]};
        return s;
    endfunction

    function automatic logic [15:0] rand_instr();
        logic [3:0] op;
        case ($urandom_range(0, 4))
            0:       op = 4'h0;
            1:       op = 4'($urandom_range(1, 7));
            2:       op = 4'h8;
            3:       op = 4'h9;
            default: op = 4'($urandom_range(10, 14));
        endcase
        return {op, 12'($urandom)};
    endfunction

    // Expected per-cycle trace of one instruction on instance k (latency k), starting at its first fetch cycle.
    task automatic build(int k, logic [15:0] ins, logic [7:0] pc, logic [7:0] da, logic [15:0] sd);
        cyc_t        c;
        logic [3:0]  op;
        logic [15:0] old;
        op  = ins[15:12];
        old = ret_m[k];
        instr_v[k] = ins;
        pc_v[k]    = pc;
        da_v[k]    = da;
        sd_v[k]    = sd;
        exp_q.delete();
        for (int i = 0; i <= k; i++) begin
            c = '0; c.busy = 1'b1; c.addr = pc; c.af = (i == k); c.ret = old;
            exp_q.push_back(c);
        end
        c = '0; c.busy = 1'b1; c.ill = (op >= 4'hA && op <= 4'hE); c.ret = old;
        exp_q.push_back(c);
        if (op == 4'h8) begin
            for (int i = 0; i <= k; i++) begin
                c = '0; c.busy = 1'b1; c.addr = da; c.rwe = (i == k); c.lsel = (i == k); c.ret = old;
                exp_q.push_back(c);
            end
        end else if (op != 4'hF) begin
            c = '0; c.busy = 1'b1; c.ret = old;
            if (op >= 4'h1 && op <= 4'h7) begin
                c.alu = 1'b1; c.rwe = 1'b1;
            end
            if (op == 4'h9) begin
                c.we = 1'b1; c.addr = da; c.wdata = sd;
            end
            exp_q.push_back(c);
        end
        ret_m[k] = old + 16'd1;
    endtask

    task automatic do_reset(int k);
        @(negedge clk);
        rst_v[k]   = 1'b1;
        start_v[k] = 1'b0;
        @(posedge clk); #1;
        rst_v[k] = 1'b0;
        ret_m[k] = '0;
    endtask

    task automatic kick(int k);
        @(negedge clk);
        start_v[k] = 1'b1;
        @(posedge clk); #1;
        start_v[k] = 1'b0;
    endtask

    task automatic test_reset();
        cyc_t got;
        for (int k = 0; k < NL; k++) begin
            rst_v[k] = 1'b1; start_v[k] = 1'b1;
            instr_v[k] = 16'h1234; pc_v[k] = 8'h11; da_v[k] = 8'h22; sd_v[k] = 16'h3333;
            ret_m[k] = '0;
        end
        repeat (3) @(posedge clk);
        for (int k = 0; k < NL; k++) begin
            @(negedge clk);
            got = sample(k);
            total++;
            if (got !== cyc_t'(0)) begin
                bad++;
                $display("FAIL reset k=%0d got=%h exp=%h", k, got, cyc_t'(0));
            end
        end
        @(posedge clk); #1;
        for (int k = 0; k < NL; k++) begin
            rst_v[k] = 1'b0; start_v[k] = 1'b0;
        end
    endtask

    task automatic test_alu();
        logic [15:0] prog [2];
        cyc_t got;
        prog[0] = 16'h1234;
        prog[1] = 16'h0000;
        for (int k = 0; k < 2; k++) begin
            do_reset(k);
            kick(k);
            for (int n = 0; n < 2; n++) begin
                build(k, prog[n], 8'($urandom), 8'($urandom), 16'($urandom));
                foreach (exp_q[i]) begin
                    @(negedge clk);
                    got = sample(k);
                    total++;
                    if (got !== exp_q[i]) begin
                        bad++;
                        $display("FAIL alu k=%0d n=%0d cyc=%0d got=%h exp=%h", k, n, i, got, exp_q[i]);
                    end
                    @(posedge clk); #1;
                end
            end
        end
    endtask

    task automatic test_load();
        logic [15:0] prog [2];
        logic [7:0]  das  [2];
        cyc_t got;
        prog[0] = {4'h8, 12'($urandom)}; das[0] = 8'h40;
        prog[1] = 16'h2001;              das[1] = 8'h00;
        do_reset(2);
        kick(2);
        for (int n = 0; n < 2; n++) begin
            build(2, prog[n], 8'($urandom), das[n], 16'($urandom));
            foreach (exp_q[i]) begin
                @(negedge clk);
                got = sample(2);
                total++;
                if (got !== exp_q[i]) begin
                    bad++;
                    $display("FAIL load n=%0d cyc=%0d got=%h exp=%h", n, i, got, exp_q[i]);
                end
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_store();
        cyc_t got;
        for (int k = 0; k < NL; k++) begin
            do_reset(k);
            kick(k);
            for (int n = 0; n < 2; n++) begin
                if (n == 0)
                    build(k, {4'h9, 12'($urandom)}, 8'($urandom), 8'h7F, 16'hBEEF);
                else
                    build(k, {4'h9, 12'($urandom)}, 8'($urandom), 8'($urandom), 16'($urandom));
                foreach (exp_q[i]) begin
                    @(negedge clk);
                    got = sample(k);
                    total++;
                    if (got !== exp_q[i]) begin
                        bad++;
                        $display("FAIL store k=%0d n=%0d cyc=%0d got=%h exp=%h", k, n, i, got, exp_q[i]);
                    end
                    @(posedge clk); #1;
                end
            end
        end
    endtask

    task automatic test_illegal();
        logic [15:0] prog [3];
        cyc_t got;
        prog[0] = 16'hC000;
        prog[1] = {4'($urandom_range(10, 14)), 12'($urandom)};
        prog[2] = 16'h0000;
        do_reset(1);
        kick(1);
        for (int n = 0; n < 3; n++) begin
            build(1, prog[n], 8'($urandom), 8'($urandom), 16'($urandom));
            foreach (exp_q[i]) begin
                @(negedge clk);
                got = sample(1);
                total++;
                if (got !== exp_q[i]) begin
                    bad++;
                    $display("FAIL illegal n=%0d cyc=%0d got=%h exp=%h", n, i, got, exp_q[i]);
                end
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_back_to_back();
        cyc_t got;
        for (int k = 0; k < NL; k++) begin
            do_reset(k);
            kick(k);
            for (int n = 0; n < 25; n++) begin
                build(k, rand_instr(), 8'($urandom), 8'($urandom), 16'($urandom));
                foreach (exp_q[i]) begin
                    @(negedge clk);
                    got = sample(k);
                    total++;
                    if (got !== exp_q[i]) begin
                        bad++;
                        $display("FAIL b2b k=%0d n=%0d cyc=%0d got=%h exp=%h", k, n, i, got, exp_q[i]);
                    end
                    @(posedge clk); #1;
                    start_v[k] = 1'($urandom);
                end
            end
            start_v[k] = 1'b0;
        end
    endtask

    task automatic test_halt();
        cyc_t got, hc;
        do_reset(1);
        kick(1);
        for (int n = 0; n < 3; n++) begin
            build(1, (n == 2) ? 16'hF000 : rand_instr(), 8'($urandom), 8'($urandom), 16'($urandom));
            foreach (exp_q[i]) begin
                @(negedge clk);
                got = sample(1);
                total++;
                if (got !== exp_q[i]) begin
                    bad++;
                    $display("FAIL halt_seq n=%0d cyc=%0d got=%h exp=%h", n, i, got, exp_q[i]);
                end
                @(posedge clk); #1;
            end
        end
        hc = '0; hc.halted = 1'b1; hc.ret = ret_m[1];
        for (int c = 0; c < 20; c++) begin
            start_v[1] = 1'($urandom);
            instr_v[1] = 16'($urandom);
            @(negedge clk);
            got = sample(1);
            total++;
            if (got !== hc) begin
                bad++;
                $display("FAIL halt_hold cyc=%0d got=%h exp=%h", c, got, hc);
            end
            @(posedge clk); #1;
        end
        rst_v[1] = 1'b1;
        @(posedge clk); #1;
        rst_v[1] = 1'b0; start_v[1] = 1'b0; ret_m[1] = '0;
        @(negedge clk);
        got = sample(1);
        total++;
        if (got !== cyc_t'(0)) begin
            bad++;
            $display("FAIL halt_reset got=%h exp=%h", got, cyc_t'(0));
        end
    endtask

    task automatic test_reset_mid_load();
        cyc_t got;
        do_reset(2);
        kick(2);
        build(2, {4'h8, 12'($urandom)}, 8'($urandom), 8'h40, 16'($urandom));
        // Indices 0..2 fetch, 3 decode, 4..6 load wait; reset lands during index 5 (second wait cycle).
        for (int i = 0; i <= 5; i++) begin
            @(negedge clk);
            got = sample(2);
            total++;
            if (got !== exp_q[i]) begin
                bad++;
                $display("FAIL midrd_pre cyc=%0d got=%h exp=%h", i, got, exp_q[i]);
            end
            if (i == 5) rst_v[2] = 1'b1;
            @(posedge clk); #1;
        end
        rst_v[2] = 1'b0;
        ret_m[2] = '0;
        @(negedge clk);
        got = sample(2);
        total++;
        if (got !== cyc_t'(0)) begin
            bad++;
            $display("FAIL midrd_reset got=%h exp=%h", got, cyc_t'(0));
        end
        @(posedge clk); #1;
        kick(2);
        for (int n = 0; n < 2; n++) begin
            build(2, (n == 0) ? 16'h3456 : 16'h8ABC, 8'($urandom), 8'($urandom), 16'($urandom));
            foreach (exp_q[i]) begin
                @(negedge clk);
                got = sample(2);
                total++;
                if (got !== exp_q[i]) begin
                    bad++;
                    $display("FAIL midrd_restart n=%0d cyc=%0d got=%h exp=%h", n, i, got, exp_q[i]);
                end
                @(posedge clk); #1;
            end
        end
    endtask

    initial begin
        #500000;
        bad++;
        $display("FAIL timeout total=%0d", total);
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_alu();
        test_load();
        test_store();
        test_illegal();
        test_back_to_back();
        test_halt();
        test_reset_mid_load();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
